// File: rtl/pkt_chk_pkg.sv
// Shared types, error codes and beat-pattern helpers for the packet checker.
package pkt_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } pkt_state_e;

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_PATTERN = 4'd1;
    localparam logic [3:0] ERR_SEQ     = 4'd2;
    localparam logic [3:0] ERR_FRAMING = 4'd3;
    localparam logic [3:0] ERR_LENGTH  = 4'd4;

    // Beat k of a packet carries the packet sequence number in the upper word
    // and the beat index in the lower word.
    function automatic logic [63:0] beat_pattern(input logic [31:0] seq,
                                                 input logic [31:0] k);
        return {seq, k};
    endfunction

    // Bytes to compare on a beat: all eight, except on the last beat where only
    // the low nbytes count (nbytes of 0 means a full beat).
    function automatic logic [63:0] byte_mask(input logic [2:0] nbytes,
                                              input logic       last);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            if (!last || (nbytes == 3'd0) || (b < int'(nbytes))) begin
                m[b*8 +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pkt_chk_satcnt.sv
// 32-bit counter that adds 0..2 per cycle, sticks at all-ones, and clears synchronously.
module pkt_chk_satcnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [1:0]  inc,
    output logic [31:0] count
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [32:0] sum;

    // Next count: clear wins, otherwise add and clamp on carry-out.
    always_comb begin
        sum = {1'b0, cnt_q} + {31'b0, inc};
        if (clr) begin
            cnt_d = '0;
        end else if (sum[32]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[31:0];
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pkt_check.sv
// Receive-side packet checker: verifies framing, length, beat pattern and
// sequence numbering of a 64-bit beat stream, with saturating statistics,
// a lock indicator and a sticky first-error code.
module pkt_check
    import pkt_chk_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 190,
    parameter int unsigned MIN_BEATS = 8,
    parameter int unsigned LOCK_CNT  = 16
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        i_link_up,
    input  logic        i_clr,
    input  logic [63:0] rx_data,
    input  logic        rx_data_en,
    input  logic        rx_data_sop,
    input  logic        rx_data_eop,
    input  logic [2:0]  rx_data_byte_vaild,
    output logic [31:0] o_good_pkts,
    output logic [31:0] o_bad_pkts,
    output logic [31:0] o_seq_errs,
    output logic        o_locked,
    output logic [3:0]  o_first_err
);

    localparam int unsigned CW = $clog2(MAX_BEATS + 1);
    localparam int unsigned LW = $clog2(LOCK_CNT + 1);

    pkt_state_e    state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]   rx_seq_q, rx_seq_d;
    logic [31:0]   exp_seq_q, exp_seq_d;
    logic          pat_err_q, pat_err_d;
    logic          seq_load_q, seq_load_d;
    logic [LW-1:0] lock_run_q, lock_run_d;
    logic          locked_q, locked_d;
    logic [3:0]    first_err_q, first_err_d;

    logic [CW-1:0] beat_k;
    logic [CW-1:0] beats_now;
    logic [31:0]   pkt_seq;
    logic          beat_mism;
    logic          pat_acc;

    logic          accept;
    logic          frame_err;
    logic          len_drop;
    logic          eval;
    logic          short_pkt;
    logic          seq_err;
    logic          pkt_bad;
    logic          pkt_good;
    logic          any_err;
    logic [3:0]    err_code;
    logic          good_inc;
    logic          seq_inc;
    logic [1:0]    bad_inc;

    // Per-beat datapath: beat index, packet seq, and pattern mismatch so far.
    always_comb begin
        beat_k    = rx_data_sop ? '0 : beat_cnt_q;
        beats_now = beat_k + CW'(1);
        pkt_seq   = rx_data_sop ? rx_data[63:32] : rx_seq_q;
        beat_mism = |((rx_data ^ beat_pattern(pkt_seq, 32'(beat_k)))
                      & byte_mask(rx_data_byte_vaild, rx_data_eop));
        pat_acc   = beat_mism | (pat_err_q & ~rx_data_sop);
    end

    // FSM next state, packet evaluation, lock tracking and first-error capture.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        rx_seq_d    = rx_seq_q;
        pat_err_d   = pat_err_q;
        exp_seq_d   = exp_seq_q;
        seq_load_d  = seq_load_q;
        lock_run_d  = lock_run_q;
        locked_d    = locked_q;
        first_err_d = first_err_q;
        accept      = 1'b0;
        frame_err   = 1'b0;
        len_drop    = 1'b0;
        eval        = 1'b0;

        if (!i_link_up) begin
            state_d    = IDLE;
            locked_d   = 1'b0;
            lock_run_d = '0;
            seq_load_d = 1'b1;
        end else if (rx_data_en) begin
            case (state_q)
                IDLE: begin
                    if (rx_data_sop) begin
                        accept = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                IN_PKT: begin
                    accept    = 1'b1;
                    frame_err = rx_data_sop;
                end
                DROP: begin
                    if (rx_data_eop) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (accept) begin
                if (rx_data_eop) begin
                    eval    = 1'b1;
                    state_d = IDLE;
                end else if (beats_now == CW'(MAX_BEATS)) begin
                    len_drop = 1'b1;
                    state_d  = DROP;
                end else begin
                    state_d    = IN_PKT;
                    beat_cnt_d = beats_now;
                    pat_err_d  = pat_acc;
                    rx_seq_d   = pkt_seq;
                end
            end
        end

        short_pkt = eval & (32'(beats_now) < MIN_BEATS);
        seq_err   = eval & ~seq_load_q & (pkt_seq != exp_seq_q);
        pkt_bad   = eval & (pat_acc | seq_err | short_pkt);
        pkt_good  = eval & ~pkt_bad;
        any_err   = frame_err | len_drop | pkt_bad;

        if (eval) begin
            exp_seq_d  = pkt_seq + 32'd1;
            seq_load_d = 1'b0;
        end

        if (any_err) begin
            lock_run_d = '0;
            locked_d   = 1'b0;
        end else if (pkt_good) begin
            if (lock_run_q < LW'(LOCK_CNT)) begin
                lock_run_d = lock_run_q + LW'(1);
            end
            if ((32'(lock_run_q) + 32'd1) >= LOCK_CNT) begin
                locked_d = 1'b1;
            end
        end

        if (eval & pat_acc) begin
            err_code = ERR_PATTERN;
        end else if (seq_err) begin
            err_code = ERR_SEQ;
        end else if (frame_err) begin
            err_code = ERR_FRAMING;
        end else if (len_drop | short_pkt) begin
            err_code = ERR_LENGTH;
        end else begin
            err_code = ERR_NONE;
        end
        if (first_err_q == ERR_NONE) begin
            first_err_d = err_code;
        end

        good_inc = pkt_good;
        seq_inc  = seq_err;
        bad_inc  = {1'b0, frame_err} + {1'b0, len_drop | pkt_bad};

        if (i_clr) begin
            state_d     = IDLE;
            lock_run_d  = '0;
            locked_d    = 1'b0;
            first_err_d = ERR_NONE;
            seq_load_d  = 1'b1;
        end
    end

    // State and tracking registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            rx_seq_q    <= '0;
            exp_seq_q   <= '0;
            pat_err_q   <= 1'b0;
            seq_load_q  <= 1'b1;
            lock_run_q  <= '0;
            locked_q    <= 1'b0;
            first_err_q <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            rx_seq_q    <= rx_seq_d;
            exp_seq_q   <= exp_seq_d;
            pat_err_q   <= pat_err_d;
            seq_load_q  <= seq_load_d;
            lock_run_q  <= lock_run_d;
            locked_q    <= locked_d;
            first_err_q <= first_err_d;
        end
    end

    pkt_chk_satcnt u_good_cnt (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .clr   (i_clr),
        .inc   ({1'b0, good_inc}),
        .count (o_good_pkts)
    );

    pkt_chk_satcnt u_bad_cnt (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .clr   (i_clr),
        .inc   (bad_inc),
        .count (o_bad_pkts)
    );

    pkt_chk_satcnt u_seq_cnt (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .clr   (i_clr),
        .inc   ({1'b0, seq_inc}),
        .count (o_seq_errs)
    );

    assign o_locked    = locked_q;
    assign o_first_err = first_err_q;

endmodule

// File: tb/tb_pkt_check.sv
// Directed bench for pkt_check: a table of single packets with hand-computed
// cumulative results, plus hand-written multi-cycle sequences.
module tb_pkt_check;

    logic        sys_clk;
    logic        rst_n;
    logic        i_link_up;
    logic        i_clr;
    logic [63:0] rx_data;
    logic        rx_data_en;
    logic        rx_data_sop;
    logic        rx_data_eop;
    logic [2:0]  rx_data_byte_vaild;
    logic [31:0] o_good_pkts;
    logic [31:0] o_bad_pkts;
    logic [31:0] o_seq_errs;
    logic        o_locked;
    logic [3:0]  o_first_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          clr_before;
        logic [31:0] seq;
        int          nbeats;
        logic [2:0]  bv;
        int          cor_beat;
        int          cor_byte;
        logic [31:0] exp_good;
        logic [31:0] exp_bad;
        logic [31:0] exp_serr;
        logic [3:0]  exp_ferr;
    } vec_t;

    vec_t vecs [17];

    pkt_check dut (
        .sys_clk            (sys_clk),
        .rst_n              (rst_n),
        .i_link_up          (i_link_up),
        .i_clr              (i_clr),
        .rx_data            (rx_data),
        .rx_data_en         (rx_data_en),
        .rx_data_sop        (rx_data_sop),
        .rx_data_eop        (rx_data_eop),
        .rx_data_byte_vaild (rx_data_byte_vaild),
        .o_good_pkts        (o_good_pkts),
        .o_bad_pkts         (o_bad_pkts),
        .o_seq_errs         (o_seq_errs),
        .o_locked           (o_locked),
        .o_first_err        (o_first_err)
    );

    // Free-running 100 MHz clock.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] good,
                            input logic [31:0] bad, input logic [31:0] serr,
                            input logic [3:0] ferr, input logic locked);
        checkOutput({tag, ".good"}, o_good_pkts, good);
        checkOutput({tag, ".bad"}, o_bad_pkts, bad);
        checkOutput({tag, ".seq"}, o_seq_errs, serr);
        checkOutput({tag, ".first_err"}, {28'b0, o_first_err}, {28'b0, ferr});
        checkOutput({tag, ".locked"}, {31'b0, o_locked}, {31'b0, locked});
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic sop,
                                 input logic eop, input logic [2:0] bv,
                                 input logic clr);
        @(negedge sys_clk);
        rx_data            = data;
        rx_data_en         = 1'b1;
        rx_data_sop        = sop;
        rx_data_eop        = eop;
        rx_data_byte_vaild = bv;
        i_clr              = clr;
    endtask

    task automatic idleCycle();
        @(negedge sys_clk);
        rx_data_en         = 1'b0;
        rx_data_sop        = 1'b0;
        rx_data_eop        = 1'b0;
        rx_data_byte_vaild = 3'd0;
        i_clr              = 1'b0;
    endtask

    task automatic pulseClear();
        idleCycle();
        i_clr = 1'b1;
        idleCycle();
    endtask

    task automatic sendPacket(input logic [31:0] seq, input int nbeats,
                              input logic [2:0] bv, input int cor_beat,
                              input int cor_byte, input bit with_eop,
                              input bit clr_on_eop);
        logic [63:0] d;
        logic        last;
        for (int k = 0; k < nbeats; k++) begin
            d = {seq, 32'(k)};
            if (k == cor_beat) begin
                d[cor_byte*8 +: 8] = d[cor_byte*8 +: 8] ^ 8'hA5;
            end
            last = with_eop && (k == nbeats - 1);
            applyStimulus(d, (k == 0), last, last ? bv : 3'd0, last && clr_on_eop);
        end
        idleCycle();
    endtask

    initial begin
        rst_n              = 1'b0;
        i_link_up          = 1'b1;
        i_clr              = 1'b0;
        rx_data            = '0;
        rx_data_en         = 1'b0;
        rx_data_sop        = 1'b0;
        rx_data_eop        = 1'b0;
        rx_data_byte_vaild = 3'd0;

        //                clr seq      beats bv    cbeat cbyte good bad  seq  ferr
        vecs[0]  = '{1'b1, 32'd5,   10,  3'd0, -1,   0,    1,   0,   0,   4'd0};
        vecs[1]  = '{1'b0, 32'd7,   10,  3'd0, -1,   0,    1,   1,   1,   4'd2};
        vecs[2]  = '{1'b0, 32'd8,   10,  3'd0, -1,   0,    2,   1,   1,   4'd2};
        vecs[3]  = '{1'b0, 32'd9,   10,  3'd3,  9,   5,    3,   1,   1,   4'd2};
        vecs[4]  = '{1'b1, 32'd10,  10,  3'd3,  9,   2,    0,   1,   0,   4'd1};
        vecs[5]  = '{1'b0, 32'd11,  10,  3'd0,  3,   2,    0,   2,   0,   4'd1};
        vecs[6]  = '{1'b0, 32'd12,   5,  3'd0, -1,   0,    0,   3,   0,   4'd1};
        vecs[7]  = '{1'b0, 32'd13,   8,  3'd0, -1,   0,    1,   3,   0,   4'd1};
        vecs[8]  = '{1'b0, 32'd14,  10,  3'd0,  0,   0,    1,   4,   0,   4'd1};
        vecs[9]  = '{1'b1, 32'd100,  1,  3'd0, -1,   0,    0,   1,   0,   4'd4};
        vecs[10] = '{1'b1, 32'd1,   10,  3'd0, -1,   0,    1,   0,   0,   4'd0};
        vecs[11] = '{1'b0, 32'd5,   10,  3'd0,  2,   0,    1,   1,   1,   4'd1};
        vecs[12] = '{1'b0, 32'd6,   10,  3'd0, -1,   0,    2,   1,   1,   4'd1};
        vecs[13] = '{1'b0, 32'd7,  190,  3'd0, -1,   0,    3,   1,   1,   4'd1};
        vecs[14] = '{1'b0, 32'd8,    7,  3'd0, -1,   0,    3,   2,   1,   4'd1};
        vecs[15] = '{1'b0, 32'd9,   10,  3'd5,  9,   4,    3,   3,   1,   4'd1};
        vecs[16] = '{1'b0, 32'd10,  10,  3'd0,  9,   7,    3,   4,   1,   4'd1};

        // Reset state.
        repeat (3) @(negedge sys_clk);
        checkAll("reset", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        idleCycle();

        // 100 in-order packets; lock appears after the 16th.
        for (int i = 0; i < 100; i++) begin
            sendPacket(32'(i), 20, 3'd0, -1, 0, 1'b1, 1'b0);
            if (i == 14) checkOutput("lock_after_15", {31'b0, o_locked}, 32'd0);
            if (i == 15) checkOutput("lock_after_16", {31'b0, o_locked}, 32'd1);
        end
        checkAll("stream100", 32'd100, 32'd0, 32'd0, 4'd0, 1'b1);

        // Link drop mid-packet: nothing counted, lock lost, seq reloads.
        for (int k = 0; k < 5; k++) begin
            applyStimulus({32'd100, 32'(k)}, (k == 0), 1'b0, 3'd0, 1'b0);
        end
        idleCycle();
        i_link_up = 1'b0;
        applyStimulus({32'd100, 32'd5}, 1'b0, 1'b1, 3'd0, 1'b0);
        idleCycle();
        idleCycle();
        i_link_up = 1'b1;
        idleCycle();
        checkAll("linkdrop", 32'd100, 32'd0, 32'd0, 4'd0, 1'b0);
        sendPacket(32'd777, 20, 3'd0, -1, 0, 1'b1, 1'b0);
        checkAll("relink", 32'd101, 32'd0, 32'd0, 4'd0, 1'b0);

        // Table of single packets with cumulative expectations.
        for (int v = 0; v < 17; v++) begin
            if (vecs[v].clr_before) pulseClear();
            sendPacket(vecs[v].seq, vecs[v].nbeats, vecs[v].bv, vecs[v].cor_beat,
                       vecs[v].cor_byte, 1'b1, 1'b0);
            checkAll($sformatf("vec%0d", v), vecs[v].exp_good, vecs[v].exp_bad,
                     vecs[v].exp_serr, vecs[v].exp_ferr, 1'b0);
        end

        // Second sop without eop aborts the first packet; stray beat in idle.
        pulseClear();
        sendPacket(32'd0, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        sendPacket(32'd1, 3, 3'd0, -1, 0, 1'b0, 1'b0);
        sendPacket(32'd1, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        checkAll("framing", 32'd2, 32'd1, 32'd0, 4'd3, 1'b0);
        applyStimulus({32'd2, 32'd0}, 1'b0, 1'b0, 3'd0, 1'b0);
        idleCycle();
        checkOutput("stray.bad", o_bad_pkts, 32'd2);

        // Overlong packet: one length error, rest dropped until eop.
        pulseClear();
        sendPacket(32'd20, 200, 3'd0, -1, 0, 1'b0, 1'b0);
        applyStimulus({32'd20, 32'd200}, 1'b0, 1'b1, 3'd0, 1'b0);
        idleCycle();
        checkAll("overlong", 32'd0, 32'd1, 32'd0, 4'd4, 1'b0);
        sendPacket(32'd21, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        checkAll("after_drop", 32'd1, 32'd1, 32'd0, 4'd4, 1'b0);

        // Sequence wrap from all-ones to zero.
        pulseClear();
        sendPacket(32'hFFFF_FFFF, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        sendPacket(32'h0000_0000, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        checkAll("wrap", 32'd2, 32'd0, 32'd0, 4'd0, 1'b0);

        // Counter saturation.
        pulseClear();
        force dut.u_good_cnt.cnt_q = 32'hFFFF_FFFE;
        force dut.u_bad_cnt.cnt_q  = 32'hFFFF_FFFE;
        idleCycle();
        idleCycle();
        release dut.u_good_cnt.cnt_q;
        release dut.u_bad_cnt.cnt_q;
        idleCycle();
        checkOutput("preset.good", o_good_pkts, 32'hFFFF_FFFE);
        sendPacket(32'd40, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        sendPacket(32'd41, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        checkOutput("sat.good", o_good_pkts, 32'hFFFF_FFFF);
        applyStimulus({32'd0, 32'd0}, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus({32'd0, 32'd0}, 1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus({32'd0, 32'd0}, 1'b0, 1'b0, 3'd0, 1'b0);
        idleCycle();
        checkOutput("sat.bad", o_bad_pkts, 32'hFFFF_FFFF);

        // Clear on the eop beat discards that packet's evaluation.
        pulseClear();
        sendPacket(32'd3, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        checkOutput("preclr.good", o_good_pkts, 32'd1);
        sendPacket(32'd9, 10, 3'd0, -1, 0, 1'b1, 1'b1);
        checkAll("clr_eop", 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
        sendPacket(32'd50, 10, 3'd0, -1, 0, 1'b1, 1'b0);
        checkAll("post_clr", 32'd1, 32'd0, 32'd0, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
